// File: rtl/adc_trigger_qual_if.sv
// Signal bundle between the ADC sample path and the level trigger qualifier.
// The master side drives samples and configuration; the slave side returns trigger results.
interface adc_trigger_qual_if #(
  parameter int DATA_W = 14,
  parameter int QUAL_W = 4,
  parameter int HOLD_W = 16,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] adc_in;
  logic              arm;
  logic [1:0]        trig_mode;
  logic [DATA_W-1:0] trig_level;
  logic [DATA_W-1:0] hysteresis;
  logic [QUAL_W-1:0] qual_count;
  logic [HOLD_W-1:0] holdoff;

  logic              trigger;
  logic              trig_dir;
  logic              armed;
  logic [DATA_W-1:0] out_pulse;
  logic [DATA_W-1:0] last_val;
  logic [QUAL_W-1:0] run_count;
  logic [CNT_W-1:0]  trig_total;

  modport master (
    output adc_in, arm, trig_mode, trig_level, hysteresis, qual_count, holdoff,
    input  trigger, trig_dir, armed, out_pulse, last_val, run_count, trig_total
  );

  modport slave (
    input  adc_in, arm, trig_mode, trig_level, hysteresis, qual_count, holdoff,
    output trigger, trig_dir, armed, out_pulse, last_val, run_count, trig_total
  );
endinterface

// File: rtl/adc_trigger_qual.sv
// ADC level trigger: edge/level qualification over N consecutive samples, hysteresis
// re-arm, holdoff, arm gating, trigger counter and a scaled pulse sample output.
module adc_trigger_qual #(
  parameter int DATA_W = 14,
  parameter int QUAL_W = 4,
  parameter int HOLD_W = 16,
  parameter int OFFSET = 8000,
  parameter int GAIN   = 10,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  adc_trigger_qual_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REARM,
    S_READY,
    S_QUALIFY,
    S_HOLDOFF
  } state_t;

  state_t            state_q;
  logic [1:0]        mode_q;
  logic              dir_q;
  logic [HOLD_W-1:0] hold_q;
  logic              trigger_q;
  logic              trig_dir_q;
  logic              armed_q;
  logic [DATA_W-1:0] out_pulse_q;
  logic [DATA_W-1:0] last_val_q;
  logic [QUAL_W-1:0] run_q;
  logic [CNT_W-1:0]  total_q;

  logic [DATA_W-1:0] lo_thr;
  logic [DATA_W:0]   hi_sum;
  logic [DATA_W-1:0] hi_thr;
  logic              rise_q, fall_q, rise_ra, fall_ra, qual;
  logic [QUAL_W-1:0] q_eff;
  logic [QUAL_W:0]   run_inc;
  logic              fire_ok;
  logic [DATA_W-1:0] pulse_val;

  // Re-arm thresholds saturate rather than wrap at the ends of the ADC range.
  assign lo_thr  = (bus.trig_level >= bus.hysteresis) ? (bus.trig_level - bus.hysteresis) : '0;
  assign hi_sum  = {1'b0, bus.trig_level} + {1'b0, bus.hysteresis};
  assign hi_thr  = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];

  assign rise_q  = (bus.adc_in > bus.trig_level) && (bus.adc_in >= last_val_q);
  assign fall_q  = (bus.adc_in < bus.trig_level) && (bus.adc_in <= last_val_q);
  assign rise_ra = (bus.adc_in <= lo_thr);
  assign fall_ra = (bus.adc_in >= hi_thr);
  assign qual    = dir_q ? rise_q : fall_q;

  // ">=" so that lowering qual_count mid-run fires immediately instead of overshooting.
  assign q_eff   = (bus.qual_count == '0) ? QUAL_W'(1) : bus.qual_count;
  assign run_inc = {1'b0, run_q} + (QUAL_W+1)'(1);
  assign fire_ok = (run_inc >= {1'b0, q_eff});

  assign pulse_val = DATA_W'((32'(bus.adc_in) - 32'(OFFSET)) * 32'(GAIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'b00;
      dir_q       <= 1'b0;
      hold_q      <= '0;
      trigger_q   <= 1'b0;
      trig_dir_q  <= 1'b0;
      armed_q     <= 1'b0;
      out_pulse_q <= '0;
      last_val_q  <= '0;
      run_q       <= '0;
      total_q     <= '0;
    end else begin
      last_val_q  <= bus.adc_in;
      trigger_q   <= 1'b0;
      out_pulse_q <= (((state_q == S_READY) || (state_q == S_QUALIFY)) && qual) ? pulse_val : '0;

      if ((state_q != S_IDLE) && !bus.arm) begin
        state_q <= S_IDLE;
        run_q   <= '0;
        armed_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.arm && (bus.trig_mode != 2'b11)) begin
              mode_q  <= bus.trig_mode;
              state_q <= S_WAIT_REARM;
            end
          end
          S_WAIT_REARM: begin
            // Falling-only mode skips the rising re-arm; rising-only skips the falling one.
            if ((mode_q != 2'b01) && rise_ra) begin
              dir_q   <= 1'b1;
              state_q <= S_READY;
              armed_q <= 1'b1;
            end else if ((mode_q != 2'b00) && fall_ra) begin
              dir_q   <= 1'b0;
              state_q <= S_READY;
              armed_q <= 1'b1;
            end
          end
          S_READY, S_QUALIFY: begin
            if (qual) begin
              if (fire_ok) begin
                trigger_q  <= 1'b1;
                trig_dir_q <= dir_q;
                total_q    <= total_q + CNT_W'(1);
                run_q      <= '0;
                hold_q     <= bus.holdoff;
                state_q    <= S_HOLDOFF;
                armed_q    <= 1'b0;
              end else begin
                run_q   <= run_inc[QUAL_W-1:0];
                state_q <= S_QUALIFY;
              end
            end else begin
              run_q   <= '0;
              state_q <= S_READY;
            end
          end
          S_HOLDOFF: begin
            if (hold_q == '0) begin
              state_q <= S_WAIT_REARM;
            end else begin
              hold_q <= hold_q - HOLD_W'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.trigger    = trigger_q;
  assign bus.trig_dir   = trig_dir_q;
  assign bus.armed      = armed_q;
  assign bus.out_pulse  = out_pulse_q;
  assign bus.last_val   = last_val_q;
  assign bus.run_count  = run_q;
  assign bus.trig_total = total_q;

endmodule

// File: tb/tb_adc_trigger_qual.sv
// Bench for adc_trigger_qual: directed scenarios plus a long randomized run
// checked cycle by cycle against a behavioural model of the trigger rules.
module tb_adc_trigger_qual;
  localparam int DW   = 14;
  localparam int QW   = 4;
  localparam int HW   = 16;
  localparam int CW   = 2;
  localparam int MAXV = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst;

  adc_trigger_qual_if #(.DATA_W(DW), .QUAL_W(QW), .HOLD_W(HW), .CNT_W(CW)) bus ();

  adc_trigger_qual #(
    .DATA_W(DW), .QUAL_W(QW), .HOLD_W(HW), .OFFSET(8000), .GAIN(10), .CNT_W(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_no = 0;

  // Model: "active" = left idle, "rearmed" = waiting for qualifying samples,
  // m_hold >= 0 while holding off after a trigger.
  bit m_active, m_rearmed;
  int m_hold, m_run, m_dir, m_mode, m_last, m_total, m_tdir;
  int e_trig, e_pulse;

  task automatic model_step();
    int adc, lvl, hy, lo, hi, q;
    bit rq, fq, ql;
    adc = int'(bus.adc_in);
    lvl = int'(bus.trig_level);
    hy  = int'(bus.hysteresis);
    if (rst) begin
      m_active = 0; m_rearmed = 0; m_hold = -1; m_run = 0; m_dir = 0;
      m_mode = 0; m_last = 0; m_total = 0; m_tdir = 0; e_trig = 0; e_pulse = 0;
      return;
    end
    rq = (adc > lvl) && (adc >= m_last);
    fq = (adc < lvl) && (adc <= m_last);
    lo = (lvl - hy < 0) ? 0 : lvl - hy;
    hi = (lvl + hy > MAXV) ? MAXV : lvl + hy;
    ql = (m_dir != 0) ? rq : fq;
    q  = (bus.qual_count == 0) ? 1 : int'(bus.qual_count);
    e_trig  = 0;
    e_pulse = (m_rearmed && ql) ? (((adc - 8000) * 10) & MAXV) : 0;
    m_last  = adc;
    if (!m_active) begin
      if (bus.arm && bus.trig_mode != 2'b11) begin
        m_active = 1;
        m_mode = int'(bus.trig_mode);
      end
    end else if (!bus.arm) begin
      m_active = 0; m_rearmed = 0; m_hold = -1; m_run = 0;
    end else if (m_hold >= 0) begin
      m_hold = (m_hold == 0) ? -1 : m_hold - 1;
    end else if (!m_rearmed) begin
      if (m_mode != 1 && adc <= lo) begin m_rearmed = 1; m_dir = 1; end
      else if (m_mode != 0 && adc >= hi) begin m_rearmed = 1; m_dir = 0; end
    end else if (ql) begin
      m_run++;
      if (m_run >= q) begin
        e_trig = 1; m_tdir = m_dir; m_total = (m_total + 1) % (1 << CW);
        m_run = 0; m_rearmed = 0; m_hold = int'(bus.holdoff);
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic cyc(input int a);
    bus.adc_in = DW'(a);
    @(posedge clk);
    #1;
    model_step();
    cyc_no++;
  endtask

  task automatic cfg(input int mode, input int lvl, input int hy, input int q, input int ho);
    bus.trig_mode  = 2'(mode);
    bus.trig_level = DW'(lvl);
    bus.hysteresis = DW'(hy);
    bus.qual_count = QW'(q);
    bus.holdoff    = HW'(ho);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1234);
    cyc(4321);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.arm = 1'b1;
    cfg(0, 9000, 100, 3, 5);
    do_reset();
    total++;
    if ({bus.trigger, bus.trig_dir, bus.armed} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %03b want 000", {bus.trigger, bus.trig_dir, bus.armed});
    end
    total++;
    if (bus.out_pulse !== '0 || bus.last_val !== '0) begin
      bad++; $display("FAIL reset_data: out_pulse=%0d last_val=%0d want 0/0", bus.out_pulse, bus.last_val);
    end
    total++;
    if (bus.run_count !== '0 || bus.trig_total !== '0) begin
      bad++; $display("FAIL reset_counts: run=%0d total=%0d want 0/0", bus.run_count, bus.trig_total);
    end
    $display("test_reset done");
  endtask

  task automatic test_rising_ramp();
    cfg(0, 9000, 100, 3, 5);
    bus.arm = 1'b1;
    do_reset();
    cyc(8800);
    cyc(8800);
    total++;
    if (bus.armed !== 1'b1) begin bad++; $display("FAIL ramp_armed: got %0b want 1", bus.armed); end
    total++;
    if (bus.last_val !== DW'(8800)) begin bad++; $display("FAIL ramp_last_val: got %0d want 8800", bus.last_val); end
    cyc(8850);
    cyc(9001);
    total++;
    if (bus.out_pulse !== DW'(10010) || bus.run_count !== QW'(1)) begin
      bad++; $display("FAIL ramp_pulse: out_pulse=%0d run=%0d want 10010/1", bus.out_pulse, bus.run_count);
    end
    cyc(9010);
    total++;
    if (bus.trigger !== 1'b0 || bus.run_count !== QW'(2)) begin
      bad++; $display("FAIL ramp_early: trig=%0b run=%0d want 0/2", bus.trigger, bus.run_count);
    end
    cyc(9020);
    total++;
    if (bus.trigger !== 1'b1 || bus.trig_dir !== 1'b1 || bus.trig_total !== CW'(1) || bus.armed !== 1'b0) begin
      bad++; $display("FAIL ramp_fire: trig=%0b dir=%0b total=%0d armed=%0b want 1/1/1/0",
                      bus.trigger, bus.trig_dir, bus.trig_total, bus.armed);
    end
    cyc(9020);
    total++;
    if (bus.trigger !== 1'b0) begin bad++; $display("FAIL ramp_one_shot: got %0b want 0", bus.trigger); end
    $display("test_rising_ramp done");
  endtask

  int first_trig_cyc;

  task automatic test_qual_break();
    int seq[7] = '{8800, 9001, 9010, 9005, 9020, 9030, 9040};
    cfg(0, 9000, 100, 3, 5);
    bus.arm = 1'b1;
    do_reset();
    cyc(8800);
    for (int i = 0; i < 7; i++) begin
      cyc(seq[i]);
      total++;
      if (bus.trigger !== 1'(i == 6)) begin
        bad++; $display("FAIL qual_break_trig[%0d]: got %0b want %0b", i, bus.trigger, (i == 6));
      end
      if (i == 3) begin
        total++;
        if (bus.run_count !== '0) begin bad++; $display("FAIL qual_break_run: got %0d want 0", bus.run_count); end
      end
    end
    first_trig_cyc = cyc_no;
    $display("test_qual_break done");
  endtask

  task automatic test_hysteresis_holdoff();
    int seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(9050);
      if (bus.trigger === 1'b1) seen++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(8950);
      if (bus.trigger === 1'b1) seen++;
    end
    total++;
    if (seen != 0 || bus.armed !== 1'b0) begin
      bad++; $display("FAIL hyst_no_retrig: triggers=%0d armed=%0b want 0/0", seen, bus.armed);
    end
    cyc(8900);
    total++;
    if (bus.armed !== 1'b1) begin bad++; $display("FAIL hyst_rearm: got %0b want 1", bus.armed); end
    cyc(9001);
    cyc(9002);
    cyc(9003);
    total++;
    if (bus.trigger !== 1'b1 || bus.trig_total !== CW'(2) || (cyc_no - first_trig_cyc) < 5) begin
      bad++; $display("FAIL hyst_second: trig=%0b total=%0d gap=%0d want 1/2/>=5",
                      bus.trigger, bus.trig_total, cyc_no - first_trig_cyc);
    end
    $display("test_hysteresis_holdoff done");
  endtask

  task automatic test_either();
    cfg(2, 8000, 0, 1, 0);
    bus.arm = 1'b1;
    do_reset();
    cyc(8000);
    cyc(8000);
    total++;
    if (bus.armed !== 1'b1) begin bad++; $display("FAIL either_rearm: got %0b want 1", bus.armed); end
    cyc(8100);
    total++;
    if (bus.trigger !== 1'b1 || bus.trig_dir !== 1'b1 || bus.out_pulse !== DW'(1000)) begin
      bad++; $display("FAIL either_rise: trig=%0b dir=%0b pulse=%0d want 1/1/1000",
                      bus.trigger, bus.trig_dir, bus.out_pulse);
    end
    cyc(8100);
    cyc(8100);
    total++;
    if (bus.armed !== 1'b1) begin bad++; $display("FAIL either_fall_rearm: got %0b want 1", bus.armed); end
    cyc(7900);
    total++;
    if (bus.trigger !== 1'b1 || bus.trig_dir !== 1'b0 || bus.out_pulse !== DW'(15384)) begin
      bad++; $display("FAIL either_fall: trig=%0b dir=%0b pulse=%0d want 1/0/15384",
                      bus.trigger, bus.trig_dir, bus.out_pulse);
    end
    $display("test_either done");
  endtask

  task automatic test_arm_drop();
    cfg(0, 9000, 100, 3, 5);
    bus.arm = 1'b1;
    do_reset();
    cyc(8800);
    cyc(8800);
    cyc(9001);
    cyc(9010);
    bus.arm = 1'b0;
    cyc(9020);
    total++;
    if (bus.trigger !== 1'b0 || bus.armed !== 1'b0 || bus.run_count !== '0 || bus.trig_total !== '0) begin
      bad++; $display("FAIL arm_drop: trig=%0b armed=%0b run=%0d total=%0d want 0/0/0/0",
                      bus.trigger, bus.armed, bus.run_count, bus.trig_total);
    end
    bus.trig_mode = 2'b11;
    bus.arm = 1'b1;
    for (int i = 0; i < 4; i++) cyc(8800);
    total++;
    if (bus.armed !== 1'b0) begin bad++; $display("FAIL mode_disabled: armed=%0b want 0", bus.armed); end
    $display("test_arm_drop done");
  endtask

  task automatic test_reset_holdoff_wrap();
    cfg(0, 9000, 100, 1, 20);
    bus.arm = 1'b1;
    do_reset();
    cyc(8800);
    cyc(8800);
    cyc(9001);
    cyc(9050);
    cyc(9050);
    do_reset();
    total++;
    if (bus.trig_total !== '0 || bus.last_val !== '0 || bus.armed !== 1'b0 || bus.trigger !== 1'b0) begin
      bad++; $display("FAIL reset_holdoff: total=%0d last=%0d armed=%0b trig=%0b want 0/0/0/0",
                      bus.trig_total, bus.last_val, bus.armed, bus.trigger);
    end
    bus.holdoff = '0;
    for (int k = 1; k <= 4; k++) begin
      cyc(8800);
      cyc(8800);
      cyc(9001);
      total++;
      if (bus.trigger !== 1'b1 || bus.trig_total !== CW'(k % 4)) begin
        bad++; $display("FAIL wrap[%0d]: trig=%0b total=%0d want 1/%0d", k, bus.trigger, bus.trig_total, k % 4);
      end
    end
    $display("test_reset_holdoff_wrap done");
  endtask

  task automatic test_random();
    int lvl, a, errs;
    int lvls[3] = '{8000, 50, 16340};
    int hys[3]  = '{0, 30, 100};
    errs = 0;
    bus.arm = 1'b1;
    cfg(0, 8000, 30, 2, 3);
    do_reset();
    lvl = 8000;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        lvl = lvls[$urandom_range(0, 2)];
        cfg(int'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2)), lvl,
            hys[$urandom_range(0, 2)], int'($urandom_range(0, 4)), int'($urandom_range(0, 6)));
      end
      if (i % 16 == 0) bus.qual_count = QW'($urandom_range(0, 4));
      bus.arm = ($urandom_range(0, 99) != 0);
      a = lvl + int'($urandom_range(0, 240)) - 120;
      if (a < 0) a = 0;
      if (a > MAXV) a = MAXV;
      cyc(a);
      total++;
      if (bus.trigger !== 1'(e_trig) || bus.trig_dir !== 1'(m_tdir) || bus.armed !== 1'(m_rearmed) ||
          bus.out_pulse !== DW'(e_pulse) || bus.last_val !== DW'(m_last) ||
          bus.run_count !== QW'(m_run) || bus.trig_total !== CW'(m_total)) begin
        bad++; errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: trig=%0b/%0d dir=%0b/%0d armed=%0b/%0b pulse=%0d/%0d last=%0d/%0d run=%0d/%0d total=%0d/%0d",
                   i, bus.trigger, e_trig, bus.trig_dir, m_tdir, bus.armed, m_rearmed, bus.out_pulse, e_pulse,
                   bus.last_val, m_last, bus.run_count, m_run, bus.trig_total, m_total);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1;
    bus.adc_in = '0;
    bus.arm = 1'b0;
    cfg(0, 9000, 100, 3, 5);
    test_reset();
    test_rising_ramp();
    test_qual_break();
    test_hysteresis_holdoff();
    test_either();
    test_arm_drop();
    test_reset_holdoff_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_trigger_qual.md
Name: adc_trigger_qual

Overview:
Parametrised next-generation ADC level trigger for the Cyclone V ADC/UART capture path. It sits between the ADC sample register and the capture/UART framing logic. It supports rising, falling, either-edge and disabled modes, and an N-consecutive-sample qualifier. It adds hysteresis re-arm, a programmable holdoff, an explicit arm control and a trigger counter, and emits a one-cycle trigger pulse plus a scaled pulse sample.

Parameters:
DATA_W, 14, ADC sample and threshold width
QUAL_W, 4, width of qualifier count / run counter
HOLD_W, 16, width of holdoff counter
OFFSET, 8000, baseline subtracted for out_pulse
GAIN, 10, multiplier for out_pulse
CNT_W, 16, width of trig_total

Ports:
clk  in  1  sample clock, all logic on rising edge
rst  in  1  synchronous active-high reset
adc_in  in  DATA_W  unsigned ADC sample, one per clk
arm  in  1  level enable; low forces IDLE
trig_mode  in  2  00 rising, 01 falling, 10 either, 11 disabled
trig_level  in  DATA_W  threshold
hysteresis  in  DATA_W  re-arm distance from threshold
qual_count  in  QUAL_W  consecutive qualifying samples required (0 treated as 1)
holdoff  in  HOLD_W  cycles spent in HOLDOFF after a trigger
trigger  out  1  registered one-cycle trigger pulse
trig_dir  out  1  1 = last trigger rising, 0 = falling
armed  out  1  high in READY or QUALIFY
out_pulse  out  DATA_W  (adc_in-OFFSET)*GAIN while qualifying, else 0
last_val  out  DATA_W  previous adc_in
run_count  out  QUAL_W  current consecutive-qualifying count
trig_total  out  CNT_W  triggers since reset, wraps

Behaviour:
- Reset (rst=1 at edge): state IDLE; trigger, trig_dir, armed, out_pulse, last_val, run_count, trig_total all 0; mode latch 00. All outputs registered.
- last_val <= adc_in every non-reset cycle, regardless of state.
- Conditions on current adc_in:
  - RISE_Q: adc_in > trig_level and adc_in >= last_val.
  - FALL_Q: adc_in < trig_level and adc_in <= last_val.
  - RISE_RA: adc_in <= sat0(trig_level - hysteresis).
  - FALL_RA: adc_in >= satmax(trig_level + hysteresis).
  - sat0 clamps at 0; satmax clamps at 2^DATA_W-1.
- Mode latched on IDLE->WAIT_REARM and held until return to IDLE. trig_level, hysteresis, qual_count and holdoff are used live.
- States:
  - IDLE: if arm and trig_mode != 11 -> WAIT_REARM (latch mode).
  - WAIT_REARM: rising mode: RISE_RA -> READY (dir=1). Falling mode: FALL_RA -> READY (dir=0). Either mode: RISE_RA -> READY dir=1, else FALL_RA -> READY dir=0; RISE_RA has priority when both are true.
  - READY: if the selected-direction qualifier is true: run_count <= 1. If effective qual_count (Q, 0 -> 1) is 1, fire -> HOLDOFF; else -> QUALIFY.
  - QUALIFY: qualifier true: run_count+1. If run_count+1 == Q, fire -> HOLDOFF. Qualifier false: run_count <= 0 -> READY.
  - Fire: trigger <= 1 for exactly one cycle; trig_dir <= dir; trig_total <= trig_total+1 (wraps); run_count <= 0; holdoff counter <= holdoff.
  - HOLDOFF: decrement each cycle. When the counter is 0 (including holdoff=0 on entry) -> WAIT_REARM if arm, else IDLE. The minimum dwell is 1 cycle.
- arm low at any edge in any non-IDLE state -> IDLE next cycle: run_count <= 0, no trigger. Arm dropping on the same edge that would fire: the drop wins, no trigger.
- Latency: trigger is high in the cycle after the edge at which the Q-th consecutive qualifying sample is on adc_in.
- out_pulse: registered (adc_in - OFFSET)*GAIN, modulo 2^DATA_W, on edges where the state is READY/QUALIFY and the qualifier is true; otherwise 0.
- armed = state in {READY, QUALIFY}, registered.
- qual_count changed mid-QUALIFY: compare uses the new value. If run_count+1 exceeds the new Q, fire on that edge (use >=).

Test Plan:
- Reset, then rising mode, level=9000, hyst=100, Q=3, holdoff=5. Ramp adc 8800,8850,9001,9010,9020 -> WAIT_REARM->READY at 8800. Trigger pulse in the cycle after the 9020 edge; trig_dir=1; trig_total=1; out_pulse at 9001 = 10010.
- Qualifier break: rising, Q=3, samples 8800,9001,9010,9005,9020,9030,9040 -> run_count resets at 9005 (non-monotonic); trigger after 9040 only.
- Hysteresis and holdoff: after a trigger, adc holds 9050 -> no retrigger. Dropping to 8950 (> 8900) -> still WAIT_REARM. Dropping to 8900 then rising above 9000 for Q samples -> second trigger, no earlier than 5 cycles after the first.
- Either mode, level=8000, hyst=0, Q=1: adc 8000 -> re-arm as rising (priority); 8100 -> trigger dir=1. Later from 8100 held ≥ FALL_RA, then 7900 -> falling trigger dir=0 after a re-arm in the rising-free branch.
- Arm drop: qualifying run at Q-1 with arm=0 on the firing edge -> no trigger, IDLE, run_count=0, armed=0. trig_mode=11 with arm=1 -> stays IDLE.
- Reset mid-HOLDOFF, and trig_total wrap with CNT_W=2 after 4 triggers -> all outputs 0 after reset; counter reads 0 after the 4th trigger.
